// File: rtl/seq3x8_decoder.sv
// Registered 3-to-8 decoder emitting timed one-hot pulses with an optional all-zero gap.
// Optional 1-entry pending code buffer is enabled by defining SEQ3X8_DECODER_QUEUE_EN.
module seq3x8_decoder #(
   parameter int unsigned PULSE_LEN = 4,
   parameter int unsigned GAP_LEN   = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i0,
   input  logic i1,
   input  logic i2,
   input  logic vld,
   output logic rdy,
   output logic o0,
   output logic o1,
   output logic o2,
   output logic o3,
   output logic o4,
   output logic o5,
   output logic o6,
   output logic o7
);

   typedef enum logic [1:0] {StIdle, StPulse, StGap} state_t;

   localparam logic [7:0] PulseInit = 8'(PULSE_LEN - 1);
   localparam logic [7:0] GapInit   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

   state_t     state;
   logic [7:0] cnt;
   logic [7:0] onehot;
   logic [2:0] code;
   logic       accept;
   logic       gap_done;

   function automatic logic [7:0] dec(input logic [2:0] c);
      dec = 8'b1 << c;
   endfunction

   assign code   = {i0, i1, i2};
   assign accept = vld && rdy;

   // Terminal cycle of the gap; with no gap this is the last pulse cycle itself.
   assign gap_done = (cnt == 8'd0) &&
                     ((state == StGap) || ((state == StPulse) && (GAP_LEN == 0)));

`ifdef SEQ3X8_DECODER_QUEUE_EN
   logic       pend;
   logic [2:0] pend_code;

   assign rdy = !rst && ((state == StIdle) || !pend);
`else
   assign rdy = !rst && (state == StIdle);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= StIdle;
         cnt    <= 8'd0;
         onehot <= 8'd0;
`ifdef SEQ3X8_DECODER_QUEUE_EN
         pend      <= 1'b0;
         pend_code <= 3'd0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (accept) begin
                  onehot <= dec(code);
                  cnt    <= PulseInit;
                  state  <= StPulse;
               end
            end
            StPulse: begin
`ifdef SEQ3X8_DECODER_QUEUE_EN
               if (accept) begin
                  pend      <= 1'b1;
                  pend_code <= code;
               end
`endif
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else if (GAP_LEN > 0) begin
                  onehot <= 8'd0;
                  cnt    <= GapInit;
                  state  <= StGap;
               end
            end
            StGap: begin
`ifdef SEQ3X8_DECODER_QUEUE_EN
               if (accept) begin
                  pend      <= 1'b1;
                  pend_code <= code;
               end
`endif
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: begin
               state  <= StIdle;
               onehot <= 8'd0;
               cnt    <= 8'd0;
            end
         endcase

         // End-of-gap action overrides the per-state updates above.
         if (gap_done) begin
`ifdef SEQ3X8_DECODER_QUEUE_EN
            if (pend) begin
               onehot <= dec(pend_code);
               cnt    <= PulseInit;
               state  <= StPulse;
               pend   <= accept;
            end else if (accept) begin
               onehot <= dec(code);
               cnt    <= PulseInit;
               state  <= StPulse;
               pend   <= 1'b0;
            end else begin
               onehot <= 8'd0;
               state  <= StIdle;
            end
`else
            onehot <= 8'd0;
            state  <= StIdle;
`endif
         end
      end
   end

   assign {o7, o6, o5, o4, o3, o2, o1, o0} = onehot;

endmodule

// File: tb/tb_seq3x8_decoder.sv
// Directed self-checking bench for seq3x8_decoder (GAP_LEN=1 and GAP_LEN=0 instances).
module tb_seq3x8_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] code;
   logic       vld_a, vld_b;
   logic       rdy_a, rdy_b;
   logic [7:0] oa, ob;
   int         errors = 0;
   int         checks = 0;

`ifdef SEQ3X8_DECODER_QUEUE_EN
   localparam logic QEN = 1'b1;
`else
   localparam logic QEN = 1'b0;
`endif

   localparam logic [7:0] ONEHOT [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                         8'h10, 8'h20, 8'h40, 8'h80};

   always #5 clk = ~clk;

   seq3x8_decoder #(.PULSE_LEN(4), .GAP_LEN(1)) u_dut_a (
      .clk(clk), .rst(rst), .i0(code[2]), .i1(code[1]), .i2(code[0]), .vld(vld_a),
      .rdy(rdy_a), .o0(oa[0]), .o1(oa[1]), .o2(oa[2]), .o3(oa[3]),
      .o4(oa[4]), .o5(oa[5]), .o6(oa[6]), .o7(oa[7])
   );

   seq3x8_decoder #(.PULSE_LEN(4), .GAP_LEN(0)) u_dut_b (
      .clk(clk), .rst(rst), .i0(code[2]), .i1(code[1]), .i2(code[0]), .vld(vld_b),
      .rdy(rdy_b), .o0(ob[0]), .o1(ob[1]), .o2(ob[2]), .o3(ob[3]),
      .o4(ob[4]), .o5(ob[5]), .o6(ob[6]), .o7(ob[7])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_a(input logic [2:0] c);
      int n = 0;
      while (!rdy_a && n < 20) begin
         tick();
         n++;
      end
      check("rdy_a_wait", {31'd0, rdy_a}, 32'd1);
      code  = c;
      vld_a = 1'b1;
      tick();
      vld_a = 1'b0;
   endtask

   task automatic send_b(input logic [2:0] c);
      int n = 0;
      while (!rdy_b && n < 20) begin
         tick();
         n++;
      end
      check("rdy_b_wait", {31'd0, rdy_b}, 32'd1);
      code  = c;
      vld_b = 1'b1;
      tick();
      vld_b = 1'b0;
   endtask

   task automatic expect_a(input string tag, input logic [7:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         check(tag, {24'd0, oa}, {24'd0, exp});
         tick();
      end
   endtask

   task automatic expect_b(input string tag, input logic [7:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         check(tag, {24'd0, ob}, {24'd0, exp});
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      code  = 3'd0;
      vld_a = 1'b1;
      vld_b = 1'b1;

      // Reset with vld asserted: must be ignored.
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_rdy_a", {31'd0, rdy_a}, 32'd0);
         check("rst_rdy_b", {31'd0, rdy_b}, 32'd0);
         check("rst_oa", {24'd0, oa}, 32'd0);
         check("rst_ob", {24'd0, ob}, 32'd0);
      end
      vld_a = 1'b0;
      vld_b = 1'b0;
      rst   = 1'b0;
      #1;
      check("post_rst_rdy_a", {31'd0, rdy_a}, 32'd1);
      check("post_rst_rdy_b", {31'd0, rdy_b}, 32'd1);
      tick();
      check("idle_oa", {24'd0, oa}, 32'd0);

      // Single code 3'b101.
      send_a(3'b101);
      for (int i = 0; i < 4; i++) begin
         check("single_o5", {24'd0, oa}, 32'h20);
         check("single_rdy_pulse", {31'd0, rdy_a}, {31'd0, QEN});
         tick();
      end
      check("single_gap", {24'd0, oa}, 32'h00);
      check("single_rdy_gap", {31'd0, rdy_a}, {31'd0, QEN});
      tick();
      check("single_idle", {24'd0, oa}, 32'h00);
      check("single_rdy_idle", {31'd0, rdy_a}, 32'd1);

      // Exhaustive decode.
      for (int c = 0; c < 8; c++) begin
         send_a(3'(c));
         expect_a($sformatf("decode_%0d", c), ONEHOT[c], 4);
         check($sformatf("decode_gap_%0d", c), {24'd0, oa}, 32'h00);
         tick();
         check($sformatf("decode_idle_rdy_%0d", c), {31'd0, rdy_a}, 32'd1);
      end

      // Reset during the second cycle of an o3 pulse.
      send_a(3'b011);
      check("midrst_c1", {24'd0, oa}, 32'h08);
`ifdef SEQ3X8_DECODER_QUEUE_EN
      code  = 3'b101;
      vld_a = 1'b1;
      tick();
      vld_a = 1'b0;
`else
      tick();
`endif
      check("midrst_c2", {24'd0, oa}, 32'h08);
      check("midrst_rdy_c2", {31'd0, rdy_a}, 32'd0);
      rst = 1'b1;
      tick();
      check("midrst_trunc", {24'd0, oa}, 32'h00);
      check("midrst_rdy_rst", {31'd0, rdy_a}, 32'd0);
      rst = 1'b0;
      expect_a("midrst_no_pulse", 8'h00, 8);
      check("midrst_rdy_after", {31'd0, rdy_a}, 32'd1);

`ifdef SEQ3X8_DECODER_QUEUE_EN
      // Queue: 3'b010, then 3'b111 at the second pulse cycle, third code held off.
      send_a(3'b010);
      check("q_c1", {24'd0, oa}, 32'h04);
      check("q_c1_rdy", {31'd0, rdy_a}, 32'd1);
      tick();
      check("q_c2", {24'd0, oa}, 32'h04);
      code  = 3'b111;
      vld_a = 1'b1;
      tick();
      check("q_c3", {24'd0, oa}, 32'h04);
      check("q_c3_rdy", {31'd0, rdy_a}, 32'd0);
      code = 3'b100;
      tick();
      check("q_c4", {24'd0, oa}, 32'h04);
      check("q_c4_rdy", {31'd0, rdy_a}, 32'd0);
      tick();
      check("q_gap", {24'd0, oa}, 32'h00);
      check("q_gap_rdy", {31'd0, rdy_a}, 32'd0);
      tick();
      check("q_c6", {24'd0, oa}, 32'h80);
      check("q_c6_rdy", {31'd0, rdy_a}, 32'd1);
      tick();
      vld_a = 1'b0;
      check("q_c7_rdy", {31'd0, rdy_a}, 32'd0);
      expect_a("q_o7", 8'h80, 3);
      expect_a("q_gap2", 8'h00, 1);
      expect_a("q_o4", 8'h10, 4);
      expect_a("q_gap3", 8'h00, 1);
      check("q_idle", {24'd0, oa}, 32'h00);
      check("q_idle_rdy", {31'd0, rdy_a}, 32'd1);

      // GAP_LEN=0: back-to-back pulses with no zero cycle.
      send_b(3'b000);
      check("g0_c1", {24'd0, ob}, 32'h01);
      code  = 3'b001;
      vld_b = 1'b1;
      tick();
      vld_b = 1'b0;
      expect_b("g0_o0", 8'h01, 3);
      expect_b("g0_o1", 8'h02, 4);
      check("g0_idle", {24'd0, ob}, 32'h00);
      check("g0_idle_rdy", {31'd0, rdy_b}, 32'd1);
`else
      // GAP_LEN=0 without the queue: back to idle right after the pulse.
      send_b(3'b000);
      expect_b("g0_o0", 8'h01, 4);
      check("g0_idle", {24'd0, ob}, 32'h00);
      check("g0_idle_rdy", {31'd0, rdy_b}, 32'd1);
      send_b(3'b001);
      expect_b("g0_o1", 8'h02, 4);
      check("g0_idle2", {24'd0, ob}, 32'h00);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
